pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V pipeline fetch stage.
- Holds the architectural fetch PC and sequences it by increment, stall-hold, branch/jump redirect and trap redirect.
- A redirect that arrives while fetch is stalled is captured and applied later, so it is never lost.
- Reports misaligned redirect targets; feeds the instruction memory address and the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; only bits [XLEN-1:0] are used.
- INC, 4, sequential increment added per advancing cycle.
- ALIGN_BITS, 2, number of low address bits that must be zero on a redirect target.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard hold; the PC does not advance while high.
- redirect_valid  in  1  branch/jump taken, from EX.
- redirect_addr  in  XLEN  branch/jump target.
- trap_valid  in  1  exception/interrupt entry.
- trap_addr  in  XLEN  trap vector target.
- pc_out  out  XLEN  current fetch PC (registered).
- pc_next_seq  out  XLEN  pc_out + INC (combinational).
- pc_valid  out  1  pc_out is a valid fetch address.
- pend_valid  out  1  a deferred redirect is held.
- misalign  out  1  one-cycle pulse: the last accepted redirect target was misaligned.
- misalign_addr  out  XLEN  the offending unmasked target.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (ports clk, reset_n).
- Reset values, applied immediately on reset_n low:
  - pc_out = RESET_VEC; pc_valid = 0.
  - pend_valid = 0; pend_addr = 0; misalign = 0; misalign_addr = 0.
  - state = BOOT.
- States: BOOT and RUN.
  - BOOT lasts exactly one clock after reset_n rises. That edge sets pc_valid = 1 and goes to RUN; pc_out stays RESET_VEC.
  - Any input asserted during BOOT is ignored.
- RUN next-PC priority, evaluated each rising edge, highest first:
  1. trap_valid: pc_out <= trap_addr. Acts even when stall=1. Clears pend_valid.
  2. redirect_valid and stall=0: pc_out <= redirect_addr. Clears pend_valid.
  3. redirect_valid and stall=1: pend_valid <= 1, pend_addr <= redirect_addr; pc_out holds. A newer redirect overwrites the held one.
  4. pend_valid and stall=0: pc_out <= pend_addr; pend_valid <= 0.
  5. stall=1: pc_out holds.
  6. Otherwise: pc_out <= pc_out + INC.
- Latency: one clock from a redirect or trap input to the new pc_out.
- Alignment: any redirect or trap target with bits [ALIGN_BITS-1:0] != 0 is loaded (or deferred) with those bits forced to 0. The same edge sets misalign = 1 and misalign_addr = the raw target. misalign returns to 0 on the next edge unless another misaligned target arrives. misalign_addr holds its value.
- Arithmetic: the increment wraps modulo 2^XLEN; no carry out, no flag.
- pc_next_seq = pc_out + INC, truncated to XLEN, valid in every state.
- Reset mid-operation discards any pending redirect and returns to BOOT.
- pc_valid stays 1 in RUN; stalls do not drop it.

Test Plan:
- Reset then run: hold reset_n low 3 cycles, release, no stall for 4 edges -> pc_out = 0, 0 (BOOT), 4, 8, 12; pc_valid rises on the first edge.
- Stall with deferred redirect: at pc_out=0x10, stall=1 for 3 cycles, redirect 0x200 in the first stall cycle -> pend_valid=1, pc_out holds 0x10; the edge after stall drops gives pc_out=0x200 and pend_valid=0; the next edge gives 0x204.
- Trap beats stall and pending: pending 0x200, stall=1, trap_valid with trap_addr=0x80 -> next pc_out=0x80, pend_valid=0.
- Simultaneous trap and redirect with stall=0: trap 0x100, redirect 0x300 -> pc_out=0x100.
- Misaligned target: redirect 0x1006 -> pc_out=0x1004, misalign pulses exactly 1 cycle, misalign_addr=0x1006.
- Wrap and async reset: redirect to 0xFFFF_FFFC, advance -> pc_out=0x0000_0000; then assert reset_n low mid-cycle with a pending redirect -> pc_out=RESET_VEC and pend_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential increment, stall hold, trap and
// branch redirect with a one-deep deferred redirect slot and misalign reporting.
module pc_unit #(
    parameter int unsigned XLEN       = 32,
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned INC        = 4,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_addr,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic            pend_valid,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pend_addr;
    logic            accept;
    logic [XLEN-1:0] raw_target;
    logic            target_misaligned;

    assign pc_next_seq = pc_out + INC_V;

    // A trap outranks a redirect, so its target is the one checked for alignment.
    assign accept            = (state == RUN) && (trap_valid || redirect_valid);
    assign raw_target        = trap_valid ? trap_addr : redirect_addr;
    assign target_misaligned = accept && ((raw_target & ~ALIGN_MASK) != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BOOT;
            pc_out        <= RESET_PC;
            pc_valid      <= 1'b0;
            pend_valid    <= 1'b0;
            pend_addr     <= '0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    misalign <= 1'b0;
                end
                RUN: begin
                    misalign <= target_misaligned;
                    if (target_misaligned) begin
                        misalign_addr <= raw_target;
                    end
                    if (trap_valid) begin
                        pc_out     <= trap_addr & ALIGN_MASK;
                        pend_valid <= 1'b0;
                    end else if (redirect_valid && !stall) begin
                        pc_out     <= redirect_addr & ALIGN_MASK;
                        pend_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        // Stalled redirect is parked; a newer one simply replaces it.
                        pend_valid <= 1'b1;
                        pend_addr  <= redirect_addr & ALIGN_MASK;
                    end else if (pend_valid && !stall) begin
                        pc_out     <= pend_addr;
                        pend_valid <= 1'b0;
                    end else if (!stall) begin
                        pc_out <= pc_out + INC_V;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit: each vector pushes its expected post-edge
// state to a scoreboard queue, which is popped and compared one step after the edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        trap_valid;
    logic [31:0] trap_addr;
    logic [31:0] pc_out;
    logic [31:0] pc_next_seq;
    logic        pc_valid;
    logic        pend_valid;
    logic        misalign;
    logic [31:0] misalign_addr;

    int n_applied     = 0;
    int n_miscompares = 0;

    pc_unit #(
        .XLEN(32), .RESET_VEC(32'h0000_0000), .INC(4), .ALIGN_BITS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .trap_valid(trap_valid), .trap_addr(trap_addr),
        .pc_out(pc_out), .pc_next_seq(pc_next_seq), .pc_valid(pc_valid),
        .pend_valid(pend_valid), .misalign(misalign), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] raddr;
        logic        tv;
        logic [31:0] taddr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_pend;
        logic        e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        pend;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[27];

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] ra,
                                input logic tv, input logic [31:0] ta,
                                input logic [31:0] pc, input logic va, input logic pe,
                                input logic mi, input logic [31:0] ma);
        vec_t v;
        v.stall = s;  v.rv = rv; v.raddr = ra; v.tv = tv; v.taddr = ta;
        v.e_pc = pc;  v.e_valid = va; v.e_pend = pe; v.e_mis = mi; v.e_maddr = ma;
        return v;
    endfunction

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] actual, input logic [31:0] expected);
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_addr  = v.raddr;
        trap_valid     = v.tv;
        trap_addr      = v.taddr;
        e.pc = v.e_pc; e.valid = v.e_valid; e.pend = v.e_pend;
        e.mis = v.e_mis; e.maddr = v.e_maddr;
        sb.push_back(e);
    endtask

    task automatic pushReset();
        exp_t e;
        e.pc = 32'h0; e.valid = 1'b0; e.pend = 1'b0; e.mis = 1'b0; e.maddr = 32'h0;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        n_applied++;
        if (sb.size() == 0) begin
            n_miscompares++;
            $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp(tag, "pc_out",        pc_out,        e.pc);
        cmp(tag, "pc_next_seq",   pc_next_seq,   e.pc + 32'd4);
        cmp(tag, "pc_valid",      {31'b0, pc_valid},   {31'b0, e.valid});
        cmp(tag, "pend_valid",    {31'b0, pend_valid}, {31'b0, e.pend});
        cmp(tag, "misalign",      {31'b0, misalign},   {31'b0, e.mis});
        cmp(tag, "misalign_addr", misalign_addr, e.maddr);
    endtask

    task automatic stepVector(input vec_t v, input string tag);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        //              stall rv  raddr          tv  taddr          pc            val pend mis maddr
        vecs[0]  = mk(1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0800, 32'h0000_0000, 1, 0, 0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0004, 1, 0, 0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0008, 1, 0, 0, 32'h0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_000C, 1, 0, 0, 32'h0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0010, 1, 0, 0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         32'h0000_0010, 1, 1, 0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0010, 1, 1, 0, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0010, 1, 1, 0, 32'h0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0200, 1, 0, 0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0204, 1, 0, 0, 32'h0);
        vecs[10] = mk(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0,         32'h0000_0204, 1, 1, 0, 32'h0);
        vecs[11] = mk(1'b1, 1'b1, 32'h0000_0340, 1'b0, 32'h0,         32'h0000_0204, 1, 1, 0, 32'h0);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0080, 32'h0000_0080, 1, 0, 0, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0080, 1, 0, 0, 32'h0);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0084, 1, 0, 0, 32'h0);
        vecs[15] = mk(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0100, 32'h0000_0100, 1, 0, 0, 32'h0);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0104, 1, 0, 0, 32'h0);
        vecs[17] = mk(1'b0, 1'b1, 32'h0000_1006, 1'b0, 32'h0,         32'h0000_1004, 1, 0, 1, 32'h0000_1006);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1008, 1, 0, 0, 32'h0000_1006);
        vecs[19] = mk(1'b1, 1'b1, 32'h0000_2003, 1'b0, 32'h0,         32'h0000_1008, 1, 1, 1, 32'h0000_2003);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_2000, 1, 0, 0, 32'h0000_2003);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_8002, 32'h0000_8000, 1, 0, 1, 32'h0000_8002);
        vecs[22] = mk(1'b0, 1'b1, 32'h0000_3001, 1'b0, 32'h0,         32'h0000_3000, 1, 0, 1, 32'h0000_3001);
        vecs[23] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 32'h0000_3001);
        vecs[24] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1, 0, 0, 32'h0000_3001);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0004, 1, 0, 0, 32'h0000_3001);
        vecs[26] = mk(1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0,         32'h0000_0004, 1, 1, 0, 32'h0000_3001);

        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        trap_valid     = 1'b0;
        trap_addr      = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        pushReset();
        checkOutput("reset_hold");
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            stepVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Pull reset mid-cycle while a redirect is parked; outputs must clear at once.
        #2;
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        trap_valid     = 1'b0;
        #1;
        pushReset();
        checkOutput("async_reset");

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stepVector(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0000, 1, 0, 0, 32'h0), "reboot");
        stepVector(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0004, 1, 0, 0, 32'h0), "after_reboot");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
